rosc_entropy_ctrl: RTL
======================

ROSC_ENTROPY_CTRL -- requirements
Module: rosc_entropy_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROSC, default 16, number of ring-oscillator instances controlled.
REQ-002 SHALL have parameter OP_WIDTH, default 8, operand width of each oscillator.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  collection enable.
REQ-006 SHALL have port opa  input  OP_WIDTH  oscillator operand A configuration.
REQ-007 SHALL have port opb  input  OP_WIDTH  oscillator operand B configuration.
REQ-008 SHALL have port sample_cycles  input  16  clocks per collected bit; 0 is treated as 1.
REQ-009 SHALL have port clr_err  input  1  single-cycle clear of health status.
REQ-010 SHALL have port rosc_dout  input  NUM_ROSC  dout bits of all oscillators.
REQ-011 SHALL have port rosc_in1  output  OP_WIDTH  registered operand A, broadcast to all oscillators.
REQ-012 SHALL have port rosc_in2  output  OP_WIDTH  registered operand B, broadcast to all oscillators.
REQ-013 SHALL have port entropy_data  output  32  collected entropy word.
REQ-014 SHALL have port entropy_valid  output  1  entropy_data holds an undelivered word.
REQ-015 SHALL have port entropy_ack  input  1  consumer accepts word.
REQ-016 SHALL have port health_err  output  1  sticky stuck-word flag.
REQ-017 SHALL have port err_cnt  output  8  saturating count of discarded words.

Function
REQ-018 SHALL implement states IDLE, COLLECT, FULL.
REQ-019 IDLE: on enable=1, SHALL load rosc_in1<=opa, rosc_in2<=opb, clear cycle and bit counters and shift register, go COLLECT; rosc_in1/rosc_in2 change only on this transition.
REQ-020 COLLECT: cycle counter SHALL increment each clock; on the clock where it equals S-1 (S = max(sample_cycles,1), sampled each cycle) it SHALL reset to 0 and shift XOR-reduction of rosc_dout into shift register LSB (shift left) and increment 5-bit bit counter.
REQ-021 On the 32nd shifted bit, if the assembled word is neither 32'h00000000 nor 32'hFFFFFFFF, SHALL load entropy_data, set entropy_valid, go FULL.
REQ-022 If the assembled word is all-zero or all-one, SHALL discard it, set health_err, increment err_cnt (saturate at 255), clear counters, stay COLLECT.
REQ-023 First valid word latency SHALL be exactly 32*S clock edges after the edge leaving IDLE, absent discards.
REQ-024 FULL: entropy_data and entropy_valid SHALL hold stable; no sampling; entropy_ack=1 SHALL clear entropy_valid on that edge and go COLLECT (enable=1, counters cleared) or IDLE (enable=0).
REQ-025 entropy_ack while entropy_valid=0 SHALL be ignored.
REQ-026 enable=0 in COLLECT SHALL abort: partial word discarded, go IDLE next edge; enable=0 in FULL SHALL NOT drop the pending word.
REQ-027 clr_err SHALL clear health_err and err_cnt; if coincident with a discard, the discard wins (health_err=1, err_cnt=1).
REQ-028 entropy_data SHALL retain its last value after ack until the next word loads.

Reset
REQ-029 nreset=0 SHALL asynchronously force IDLE, rosc_in1=0, rosc_in2=0, entropy_data=0, entropy_valid=0, health_err=0, err_cnt=0, all counters and shift register 0, including mid-COLLECT or FULL.

Verification
REQ-030 S=4, rosc_dout alternating 16'h0001/16'h0000 per bit period, enable=1 -> entropy_valid after 128 edges, entropy_data=32'hAAAAAAAA, ack -> valid low next edge.
REQ-031 rosc_dout=16'h0003 constant, S=1 -> every word 32'h00000000 discarded, entropy_valid never rises, err_cnt increments every 32 edges, saturates at 255; clr_err -> 0.
REQ-032 sample_cycles=0 -> behaves as S=1, word in 32 edges.
REQ-033 enable dropped after 10 bits -> IDLE, no valid; re-enable with opa=8'h5A, opb=8'hC3 -> rosc_in1=8'h5A, rosc_in2=8'hC3, full 32*S latency restarts.
REQ-034 FULL with ack held low 100 cycles, then enable=0 then ack -> data stable throughout, IDLE after ack; nreset pulse mid-FULL -> all outputs 0 immediately.

Source files
------------

// File: rtl/rosc_entropy_ctrl_if.sv
// rtl/rosc_entropy_ctrl_if.sv - entropy word handshake between collector and consumer
interface rosc_entropy_ctrl_if;
  logic [31:0] entropy_data;
  logic        entropy_valid;
  logic        entropy_ack;

  modport master (output entropy_data, output entropy_valid, input entropy_ack);
  modport slave  (input entropy_data, input entropy_valid, output entropy_ack);
endinterface

// File: rtl/rosc_entropy_ctrl.sv
// rtl/rosc_entropy_ctrl.sv - ring-oscillator entropy collector with stuck-word health check
module rosc_entropy_ctrl #(
  parameter int NUM_ROSC = 16,
  parameter int OP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                enable,
  input  logic [OP_WIDTH-1:0] opa,
  input  logic [OP_WIDTH-1:0] opb,
  input  logic [15:0]         sample_cycles,
  input  logic                clr_err,
  input  logic [NUM_ROSC-1:0] rosc_dout,
  output logic [OP_WIDTH-1:0] rosc_in1,
  output logic [OP_WIDTH-1:0] rosc_in2,
  output logic                health_err,
  output logic [7:0]          err_cnt,
  rosc_entropy_ctrl_if.master ent
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [4:0]          bit_q, bit_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                herr_q, herr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [OP_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [15:0]         last_cyc;
  logic [31:0]         word;

  // sample_cycles of 0 behaves like 1, so the terminal count is 0 in both cases
  assign last_cyc = (sample_cycles == 16'd0) ? 16'd0 : sample_cycles - 16'd1;
  assign word     = {shift_q[30:0], ^rosc_dout};

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    herr_d    = herr_q;
    err_cnt_d = err_cnt_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    if (clr_err) begin
      herr_d    = 1'b0;
      err_cnt_d = 8'd0;
    end
    case (state_q)
      IDLE: begin
        if (enable) begin
          in1_d   = opa;
          in2_d   = opb;
          cyc_d   = 16'd0;
          bit_d   = 5'd0;
          shift_d = 32'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (!enable) begin
          cyc_d   = 16'd0;
          bit_d   = 5'd0;
          shift_d = 32'd0;
          state_d = IDLE;
        end else if (cyc_q >= last_cyc) begin
          cyc_d   = 16'd0;
          shift_d = word;
          bit_d   = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            shift_d = 32'd0;
            if (word != 32'h0000_0000 && word != 32'hFFFF_FFFF) begin
              data_d  = word;
              valid_d = 1'b1;
              state_d = FULL;
            end else begin
              // a discard overrides a coincident clear
              herr_d    = 1'b1;
              err_cnt_d = (err_cnt_d == 8'hFF) ? 8'hFF : err_cnt_d + 8'd1;
            end
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      FULL: begin
        if (ent.entropy_ack) begin
          valid_d = 1'b0;
          cyc_d   = 16'd0;
          bit_d   = 5'd0;
          shift_d = 32'd0;
          state_d = enable ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cyc_q     <= 16'd0;
      bit_q     <= 5'd0;
      shift_q   <= 32'd0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
      herr_q    <= 1'b0;
      err_cnt_q <= 8'd0;
      in1_q     <= '0;
      in2_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      herr_q    <= herr_d;
      err_cnt_q <= err_cnt_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
    end
  end

  assign rosc_in1          = in1_q;
  assign rosc_in2          = in2_q;
  assign health_err        = herr_q;
  assign err_cnt           = err_cnt_q;
  assign ent.entropy_data  = data_q;
  assign ent.entropy_valid = valid_q;

endmodule
